// File: rtl/data_recorder_mc.sv
// Multi-lane record/playback buffer on the register bus: plays lane RAMs out on data_out
// or captures data_in into them, with CPU access through a shared pointer.
module data_recorder_mc #(
    parameter int          BUS_ADDR_WIDTH = 30,
    parameter logic [31:0] BASE_ADDR      = 32'h52000000 / 32'd4,
    parameter int          NUM_PORTS      = 4,
    parameter int          DATA_WIDTH     = 16,
    parameter int          DATA_DEPTH     = 1024,
    parameter logic [31:0] CONST_VAL      = 32'hDA7A0002
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    input  logic                            valid_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                            valid_out,
    output logic                            done,
    input  logic [BUS_ADDR_WIDTH-1:0]       bus_addr,
    input  logic [31:0]                     bus_wdata,
    output logic [31:0]                     bus_rdata,
    input  logic                            bus_wr,
    input  logic                            bus_rd
);

    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int CW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LW = NUM_PORTS * DATA_WIDTH;
    localparam logic [BUS_ADDR_WIDTH-1:0] BASE_W = BUS_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    localparam logic [2:0] R_CONST  = 3'd0;
    localparam logic [2:0] R_CTRL   = 3'd1;
    localparam logic [2:0] R_CHAN   = 3'd2;
    localparam logic [2:0] R_RAM    = 3'd3;
    localparam logic [2:0] R_DEPTH  = 3'd4;
    localparam logic [2:0] R_LOOPS  = 3'd5;
    localparam logic [2:0] R_STATUS = 3'd6;
    localparam logic [2:0] R_PTR    = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_CAPTURE, ST_DONE} state_t;

    state_t                 state_r;
    logic                   start_r;
    logic                   mode_r;
    logic [31:0]            chan_r;
    logic [31:0]            depth_r;
    logic [15:0]            loops_r;
    logic [AW-1:0]          ptr_r;
    logic [AW-1:0]          addr_r;
    logic [15:0]            cnt_r;
    logic                   rd_valid_r;
    logic                   done_flag_r;
    logic                   err_r;
    logic                   rd_pend_r;
    logic [31:0]            rd_stage_r;
    logic [LW-1:0]          lane_rd_r;
    logic [DATA_WIDTH-1:0]  mem_r [NUM_PORTS][DATA_DEPTH];

    logic [BUS_ADDR_WIDTH-1:0] offset_s;
    logic                   hit_s;
    logic [2:0]             reg_sel_s;
    logic                   wr_s;
    logic                   ctrl_wr_s;
    logic                   srst_s;
    logic                   start_rise_s;
    logic                   stop_s;
    logic                   ram_wr_s;
    logic                   ram_rd_s;
    logic                   ptr_wr_s;
    logic                   busy_s;
    logic                   cpu_we_s;
    logic                   cap_we_s;
    logic [CW-1:0]          chan_idx_s;
    logic [AW:0]            eff_depth_s;
    logic [AW-1:0]          last_addr_s;
    logic [31:0]            status_s;
    logic [31:0]            rd_mux_s;

    // Bus decode, effective pass length and lane selection
    always_comb begin
        offset_s     = bus_addr - BASE_W;
        hit_s        = (offset_s[BUS_ADDR_WIDTH-1:3] == '0);
        reg_sel_s    = offset_s[2:0];
        wr_s         = bus_wr & hit_s;
        ctrl_wr_s    = wr_s & (reg_sel_s == R_CTRL);
        srst_s       = ctrl_wr_s & bus_wdata[0];
        start_rise_s = ctrl_wr_s & bus_wdata[1] & ~start_r;
        stop_s       = ctrl_wr_s & ~bus_wdata[1];
        ram_wr_s     = wr_s & (reg_sel_s == R_RAM);
        ram_rd_s     = bus_rd & hit_s & (reg_sel_s == R_RAM);
        ptr_wr_s     = wr_s & (reg_sel_s == R_PTR);
        busy_s       = (state_r != ST_IDLE);
        cpu_we_s     = ram_wr_s & ~busy_s & ~reset;
        cap_we_s     = (state_r == ST_CAPTURE) & valid_in & ~reset & ~srst_s & ~stop_s;
        if (chan_r < 32'(NUM_PORTS)) begin
            chan_idx_s = chan_r[CW-1:0];
        end else begin
            chan_idx_s = '0;
        end
        if ((depth_r == 32'd0) || (depth_r > 32'(DATA_DEPTH))) begin
            eff_depth_s = (AW+1)'(DATA_DEPTH);
        end else begin
            eff_depth_s = depth_r[AW:0];
        end
        last_addr_s = AW'(eff_depth_s - (AW+1)'(1));
        status_s    = {cnt_r, 13'd0, err_r, done_flag_r, busy_s};
        case (reg_sel_s)
            R_CONST:  rd_mux_s = CONST_VAL;
            R_CTRL:   rd_mux_s = {29'd0, mode_r, start_r, 1'b0};
            R_CHAN:   rd_mux_s = chan_r;
            R_RAM:    rd_mux_s = 32'(mem_r[chan_idx_s][ptr_r]);
            R_DEPTH:  rd_mux_s = depth_r;
            R_LOOPS:  rd_mux_s = {16'd0, loops_r};
            R_STATUS: rd_mux_s = status_s;
            R_PTR:    rd_mux_s = 32'(ptr_r);
            default:  rd_mux_s = 32'd0;
        endcase
        if (!hit_s) begin
            rd_mux_s = 32'd0;
        end else begin
            rd_mux_s = rd_mux_s;
        end
    end

    // Writable configuration registers and the CPU RAM pointer
    always_ff @(posedge clk) begin
        if (reset || srst_s) begin
            start_r <= 1'b0;
            mode_r  <= 1'b0;
            chan_r  <= 32'd0;
            depth_r <= 32'(DATA_DEPTH);
            loops_r <= 16'd1;
            ptr_r   <= '0;
        end else begin
            if (wr_s) begin
                case (reg_sel_s)
                    R_CTRL: begin
                        start_r <= bus_wdata[1];
                        mode_r  <= bus_wdata[2];
                    end
                    R_CHAN:  chan_r  <= bus_wdata;
                    R_DEPTH: depth_r <= bus_wdata;
                    R_LOOPS: loops_r <= bus_wdata[15:0];
                    default: ;
                endcase
            end
            // A dropped RAM write still consumes its pointer slot
            if (ptr_wr_s) begin
                ptr_r <= bus_wdata[AW-1:0];
            end else if (ram_wr_s || ram_rd_s) begin
                ptr_r <= ptr_r + ADDR_ONE;
            end
        end
    end

    // Two-stage read return: sample the register, then present it on bus_rdata
    always_ff @(posedge clk) begin
        if (reset || srst_s) begin
            rd_pend_r  <= 1'b0;
            rd_stage_r <= 32'd0;
            bus_rdata  <= 32'd0;
        end else begin
            rd_pend_r <= bus_rd;
            if (bus_rd) begin
                rd_stage_r <= rd_mux_s;
            end
            if (rd_pend_r) begin
                bus_rdata <= rd_stage_r;
            end
        end
    end

    // Playback/capture sequencer with registered datapath outputs
    always_ff @(posedge clk) begin
        if (reset || srst_s) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            cnt_r       <= 16'd0;
            rd_valid_r  <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            done        <= 1'b0;
            done_flag_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ptr_wr_s) begin
                done_flag_r <= 1'b0;
                err_r       <= 1'b0;
            end
            if (ram_wr_s && busy_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    rd_valid_r <= 1'b0;
                    if (start_rise_s) begin
                        addr_r  <= '0;
                        cnt_r   <= 16'd0;
                        state_r <= bus_wdata[2] ? ST_CAPTURE : ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop_s) begin
                        rd_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        rd_valid_r <= 1'b1;
                        if (addr_r == last_addr_s) begin
                            addr_r <= '0;
                            cnt_r  <= cnt_r + 16'd1;
                            if ((loops_r != 16'd0) && ((cnt_r + 16'd1) == loops_r)) begin
                                state_r <= ST_DONE;
                            end
                        end else begin
                            addr_r <= addr_r + ADDR_ONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    rd_valid_r <= 1'b0;
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                    end else if (valid_in) begin
                        cnt_r <= cnt_r + 16'd1;
                        if (addr_r == last_addr_s) begin
                            addr_r  <= '0;
                            state_r <= ST_DONE;
                        end else begin
                            addr_r <= addr_r + ADDR_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    rd_valid_r  <= 1'b0;
                    done        <= 1'b1;
                    done_flag_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    rd_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
            valid_out <= rd_valid_r;
            data_out  <= rd_valid_r ? lane_rd_r : '0;
        end
    end

    // Lane RAMs: capture writes every lane, CPU writes only the selected lane when idle
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (cap_we_s) begin
                mem_r[k][addr_r] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end else if (cpu_we_s && (chan_idx_s == CW'(k))) begin
                mem_r[k][ptr_r] <= bus_wdata[DATA_WIDTH-1:0];
            end
            lane_rd_r[k*DATA_WIDTH +: DATA_WIDTH] <= mem_r[k][addr_r];
        end
    end

endmodule

// File: tb/tb_data_recorder_mc.sv
// Self-checking bench for data_recorder_mc: register table, directed play/capture
// sequences and randomized runs checked against a word-list model of the lane RAMs.
module tb_data_recorder_mc;
    localparam int NP = 4;
    localparam int DW = 16;
    localparam int DD = 1024;
    localparam int BAW = 30;
    localparam logic [31:0] BASE = 32'h52000000 / 32'd4;
    localparam logic [31:0] CONSTV = 32'hDA7A0002;
    localparam logic [2:0] O_CONST = 3'd0, O_CTRL = 3'd1, O_CHAN = 3'd2, O_RAM = 3'd3;
    localparam logic [2:0] O_DEPTH = 3'd4, O_LOOPS = 3'd5, O_STATUS = 3'd6, O_PTR = 3'd7;

    logic clk = 1'b0;
    logic reset;
    logic [NP*DW-1:0] data_in, data_out;
    logic valid_in, valid_out, done;
    logic [BAW-1:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic bus_wr, bus_rd;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mm [NP][DD];

    typedef struct {
        logic [2:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    data_recorder_mc dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .done(done),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_wr(bus_wr), .bus_rd(bus_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr_abs(input logic [BAW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        wr_abs(BAW'(BASE + 32'(off)), d);
    endtask

    task automatic rd_abs(input logic [BAW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_rd = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        @(negedge clk);
        d = bus_rdata;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        rd_abs(BAW'(BASE + 32'(off)), d);
    endtask

    task automatic ram_write(input int lane, input int a, input logic [DW-1:0] v);
        wr(O_CHAN, 32'(lane));
        wr(O_PTR, 32'(a));
        wr(O_RAM, 32'(v));
        mm[lane][a] = v;
    endtask

    function automatic int eff_depth(input int d);
        return (d == 0 || d > DD) ? DD : d;
    endfunction

    // Finite PLAY run: expected stream is every lane's first eff words, repeated loops times
    task automatic run_play(input int depth_w, input int loops, input string nm);
        logic [NP*DW-1:0] expq[$];
        logic [NP*DW-1:0] w;
        logic [31:0] r;
        int eff, n, dones, first, gaps, zbad;
        bit last_v;
        eff = eff_depth(depth_w);
        for (int p = 0; p < loops; p++)
            for (int i = 0; i < eff; i++) begin
                for (int k = 0; k < NP; k++) w[k*DW +: DW] = mm[k][i];
                expq.push_back(w);
            end
        wr(O_DEPTH, 32'(depth_w));
        wr(O_LOOPS, 32'(loops));
        wr(O_PTR, 32'd0);
        wr(O_CTRL, 32'd0);
        wr(O_CTRL, 32'd2);
        n = 0; dones = 0; first = -1; gaps = 0; zbad = 0; last_v = 1'b0;
        for (int c = 0; c < eff * loops + 20; c++) begin
            @(negedge clk);
            if (valid_out) begin
                if (first < 0) first = c;
                else if (!last_v) gaps++;
                if (n < expq.size()) chk({nm, " word"}, data_out, expq[n]);
                n++;
            end else if (data_out !== '0) begin
                zbad++;
            end
            if (done) dones++;
            last_v = valid_out;
        end
        chk({nm, " word count"}, 64'(n), 64'(expq.size()));
        chk({nm, " start latency"}, 64'(first), 64'd1);
        chk({nm, " gaps"}, 64'(gaps), 64'd0);
        chk({nm, " done pulses"}, 64'(dones), 64'd1);
        chk({nm, " data zero when idle"}, 64'(zbad), 64'd0);
        rd(O_STATUS, r);
        chk({nm, " status"}, 64'(r), 64'({16'(loops), 16'h0002}));
    endtask

    // CAPTURE run with random or alternating valid_in, then lane readback via CPU
    task automatic run_capture(input int depth_w, input bit t4, input string nm);
        logic [NP*DW-1:0] w;
        logic [31:0] r;
        int eff, cnt, dones, vbad;
        bit vin;
        eff = eff_depth(depth_w);
        wr(O_DEPTH, 32'(depth_w));
        wr(O_CTRL, 32'd0);
        valid_in = 1'b1;
        data_in = {$urandom, $urandom};
        wr(O_CTRL, 32'd6);
        cnt = 0; dones = 0; vbad = 0;
        for (int c = 0; c < 3 * eff + 20; c++) begin
            vin = t4 ? (c % 2 == 0) : ((c % 2 == 0) || ($urandom_range(1) == 1));
            for (int k = 0; k < NP; k++)
                w[k*DW +: DW] = (t4 && k == 1) ? DW'(16'hA0 + 16'(cnt)) : DW'($urandom);
            valid_in = vin;
            data_in = w;
            if (vin && cnt < eff) begin
                for (int k = 0; k < NP; k++) mm[k][cnt] = w[k*DW +: DW];
                cnt++;
            end
            @(negedge clk);
            if (done) dones++;
            if (valid_out) vbad++;
        end
        valid_in = 1'b0;
        chk({nm, " done pulses"}, 64'(dones), 64'd1);
        chk({nm, " valid_out during capture"}, 64'(vbad), 64'd0);
        rd(O_STATUS, r);
        chk({nm, " status"}, 64'(r), 64'({16'(eff), 16'h0002}));
        for (int k = 0; k < NP; k++) begin
            wr(O_CHAN, 32'(k));
            wr(O_PTR, 32'd0);
            for (int i = 0; i < eff; i++) begin
                rd(O_RAM, r);
                chk({nm, " readback"}, 64'(r), 64'(mm[k][i]));
            end
        end
    endtask

    initial begin
        reg_vec_t vecs[$];
        logic [31:0] r;
        logic [DW-1:0] x, y;
        int nv, dones;

        reset = 1'b1; valid_in = 1'b0; data_in = '0;
        bus_addr = '0; bus_wdata = 32'd0; bus_wr = 1'b0; bus_rd = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // T1: reset state
        chk("reset valid_out", 64'(valid_out), 64'd0);
        chk("reset data_out", data_out, 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset bus_rdata", 64'(bus_rdata), 64'd0);
        rd(O_CONST, r);   chk("const", 64'(r), 64'(CONSTV));
        repeat (3) @(negedge clk);
        chk("rdata hold", 64'(bus_rdata), 64'(CONSTV));
        rd(O_STATUS, r);  chk("reset status", 64'(r), 64'd0);
        rd(O_DEPTH, r);   chk("reset depth", 64'(r), 64'(DD));
        rd(O_LOOPS, r);   chk("reset loops", 64'(r), 64'd1);

        // Register write/readback table
        vecs = '{
            '{O_CHAN, 32'd3, 32'd3}, '{O_CHAN, 32'd9, 32'd9}, '{O_CHAN, 32'd0, 32'd0},
            '{O_DEPTH, 32'd5, 32'd5}, '{O_DEPTH, 32'd1024, 32'd1024},
            '{O_LOOPS, 32'h0001_2345, 32'h0000_2345}, '{O_LOOPS, 32'd1, 32'd1},
            '{O_PTR, 32'h405, 32'h5}, '{O_PTR, 32'd0, 32'd0},
            '{O_CTRL, 32'd4, 32'd4}, '{O_CTRL, 32'd0, 32'd0},
            '{O_CONST, 32'h1234_5678, CONSTV}, '{O_STATUS, 32'hFFFF_FFFF, 32'd0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            wr(vecs[i].off, vecs[i].wdata);
            rd(vecs[i].off, r);
            chk($sformatf("regvec%0d", i), 64'(r), 64'(vecs[i].exp));
        end
        rd_abs(BAW'(BASE + 32'd8), r);  chk("unmapped read above", 64'(r), 64'd0);
        rd_abs(BAW'(BASE - 32'd1), r);  chk("unmapped read below", 64'(r), 64'd0);
        wr(O_CHAN, 32'd1);
        wr_abs(BAW'(BASE + 32'd10), 32'd2);
        rd(O_CHAN, r);  chk("unmapped write ignored", 64'(r), 64'd1);

        // Preload all lane RAMs with random words
        for (int k = 0; k < NP; k++) begin
            wr(O_CHAN, 32'(k));
            wr(O_PTR, 32'd0);
            for (int i = 0; i < DD; i++) begin
                mm[k][i] = DW'($urandom);
                wr(O_RAM, 32'(mm[k][i]));
            end
        end

        // Pointer wrap and out-of-range lane select
        x = DW'($urandom); y = DW'($urandom);
        wr(O_CHAN, 32'd2); wr(O_PTR, 32'd1023);
        wr(O_RAM, 32'(x)); wr(O_RAM, 32'(y));
        mm[2][1023] = x; mm[2][0] = y;
        rd(O_PTR, r);  chk("ptr wrap", 64'(r), 64'd1);
        wr(O_PTR, 32'd1023);
        rd(O_RAM, r);  chk("wrap read 1023", 64'(r), 64'(x));
        rd(O_RAM, r);  chk("wrap read 0", 64'(r), 64'(y));
        wr(O_CHAN, 32'd9); wr(O_PTR, 32'd5);
        rd(O_RAM, r);  chk("chan>=NP maps lane0", 64'(r), 64'(mm[0][5]));

        // T2: lane0 1..8, two passes
        for (int i = 0; i < 8; i++) ram_write(0, i, DW'(i + 1));
        run_play(8, 2, "t2");

        // T5: every lane loaded with its own sequence
        for (int k = 0; k < NP; k++)
            for (int i = 0; i < 4; i++) ram_write(k, i, DW'(k * 16 + i));
        run_play(4, 1, "t5");

        // T3: endless play, then stop
        for (int i = 0; i < 3; i++) ram_write(0, i, DW'(5 + i));
        wr(O_DEPTH, 32'd3); wr(O_LOOPS, 32'd0); wr(O_CTRL, 32'd0); wr(O_CTRL, 32'd2);
        nv = 0; dones = 0;
        for (int c = 0; c < 100 && nv < 20; c++) begin
            @(negedge clk);
            if (valid_out) begin
                chk("t3 data", 64'(data_out[DW-1:0]), 64'(5 + nv % 3));
                nv++;
            end
            if (done) dones++;
        end
        chk("t3 reached 20 words", 64'(nv), 64'd20);
        bus_addr = BAW'(BASE + 32'(O_CTRL)); bus_wdata = 32'd0; bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
        if (valid_out) chk("t3 tail data", 64'(data_out[DW-1:0]), 64'(5 + nv % 3));
        if (done) dones++;
        @(negedge clk);
        chk("t3 stop latency", 64'(valid_out), 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid_out || done) dones++;
        end
        chk("t3 no done / stays low", 64'(dones), 64'd0);
        rd(O_STATUS, r);  chk("t3 not busy", 64'(r[0]), 64'd0);

        // T4: capture, lane1 = A0..A3 on alternate cycles
        run_capture(4, 1'b1, "t4");

        // Randomized play and capture runs
        for (int it = 0; it < 6; it++) begin
            ram_write($urandom_range(NP - 1), $urandom_range(15), DW'($urandom));
            run_play($urandom_range(20, 1), $urandom_range(3, 1), $sformatf("rplay%0d", it));
        end
        run_play(1, 3, "depth1");
        run_play(0, 1, "depth0");
        run_play(2000, 1, "depthbig");
        for (int it = 0; it < 3; it++)
            run_capture($urandom_range(12, 1), 1'b0, $sformatf("rcap%0d", it));

        // T6: RAM access while playing, then hard reset mid-play
        for (int i = 0; i < 4; i++) ram_write(0, i, DW'($urandom));
        wr(O_DEPTH, 32'd4); wr(O_LOOPS, 32'd0); wr(O_CTRL, 32'd0); wr(O_CTRL, 32'd2);
        wr(O_CHAN, 32'd0); wr(O_PTR, 32'd2);
        rd(O_RAM, r);  chk("t6 busy read", 64'(r), 64'(mm[0][2]));
        wr(O_RAM, 32'(~mm[0][3]));
        rd(O_STATUS, r);  chk("t6 err+busy", 64'(r[2:0]), 64'b101);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t6 reset valid_out", 64'(valid_out), 64'd0);
        chk("t6 reset data_out", data_out, 64'd0);
        chk("t6 reset bus_rdata", 64'(bus_rdata), 64'd0);
        reset = 1'b0;
        rd(O_CTRL, r);   chk("t6 ctrl", 64'(r), 64'd0);
        rd(O_CHAN, r);   chk("t6 chan", 64'(r), 64'd0);
        rd(O_DEPTH, r);  chk("t6 depth", 64'(r), 64'(DD));
        rd(O_LOOPS, r);  chk("t6 loops", 64'(r), 64'd1);
        rd(O_STATUS, r); chk("t6 status", 64'(r), 64'd0);
        rd(O_PTR, r);    chk("t6 ptr", 64'(r), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd(O_RAM, r);  chk("t6 ram intact", 64'(r), 64'(mm[0][i]));
        end

        // Soft reset through CTRL[0] mid-play
        wr(O_LOOPS, 32'd0); wr(O_CTRL, 32'd2); wr(O_CHAN, 32'd2);
        repeat (4) @(negedge clk);
        chk("srst precondition valid", 64'(valid_out), 64'd1);
        wr(O_CTRL, 32'd3);
        chk("srst valid_out", 64'(valid_out), 64'd0);
        rd(O_CHAN, r);   chk("srst chan", 64'(r), 64'd0);
        rd(O_CTRL, r);   chk("srst ctrl", 64'(r), 64'd0);
        rd(O_DEPTH, r);  chk("srst depth", 64'(r), 64'(DD));
        rd(O_STATUS, r); chk("srst status", 64'(r), 64'd0);
        chk("srst stays idle", 64'(valid_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
